// File: rtl/mmio_gpio_pkg.sv
// Shared constants for the memory-mapped GPIO block: register word indices,
// bus FSM state encodings and the debounce counter sizing helper.
package mmio_gpio_pkg;

  localparam logic [2:0] REG_OUT    = 3'd0;
  localparam logic [2:0] REG_SET    = 3'd1;
  localparam logic [2:0] REG_CLR    = 3'd2;
  localparam logic [2:0] REG_TOG    = 3'd3;
  localparam logic [2:0] REG_IN     = 3'd4;
  localparam logic [2:0] REG_RISE   = 3'd5;
  localparam logic [2:0] REG_FALL   = 3'd6;
  localparam logic [2:0] REG_IRQ_EN = 3'd7;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  // A zero-cycle (bypass) debouncer still needs a 1-bit counter to elaborate.
  function automatic int deb_cnt_w(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/mmio_gpio_if.sv
// CPU valid/ready memory bus as seen by one peripheral behind the decoder.
interface mmio_gpio_if;

  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/mmio_gpio_debounce.sv
// One input pin: 2-flop synchroniser, stability counter and debounced level,
// with single-cycle rise/fall pulses aligned to the edge that updates the level.
module mmio_gpio_debounce
  import mmio_gpio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int              CW    = deb_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   LIMIT = CW'(DEBOUNCE_CYCLES);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          w_accept;

  assign w_accept = (r_sync2 != r_level) && (r_cnt == LIMIT);

  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      if ((r_sync2 == r_level) || w_accept) r_cnt <= '0;
      else                                   r_cnt <= r_cnt + 1'b1;
      if (w_accept) r_level <= r_sync2;
    end
  end

  assign o_level = r_level;
  assign o_rise  = w_accept &  r_sync2;
  assign o_fall  = w_accept & ~r_sync2;

endmodule

// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO: byte-strobed OUT with atomic set/clear/toggle, debounced
// inputs with w1c edge status, and a maskable registered interrupt.
module mmio_gpio
  import mmio_gpio_pkg::*;
#(
  parameter int               OUT_W           = 8,
  parameter int               IN_W            = 7,
  parameter logic [OUT_W-1:0] OUT_RESET       = '0,
  parameter int               DEBOUNCE_CYCLES = 250000
) (
  input  logic             clk,
  input  logic             reset_n,
  mmio_gpio_if.slave       bus,
  input  logic [IN_W-1:0]  i_gpio_in,
  output logic [OUT_W-1:0] o_gpio_out,
  output logic             o_irq
);

  logic [0:0]      r_state;
  logic [31:0]     r_rdata;
  logic [OUT_W-1:0] r_out;
  logic [IN_W-1:0] r_rise, r_fall, r_en_rise, r_en_fall;
  logic            r_irq;

  logic [IN_W-1:0] w_in, w_rise_p, w_fall_p, w_rise_clr, w_fall_clr;
  logic [2:0]      w_idx;
  logic            w_req, w_wr;
  logic [31:0]     w_bmask, w_wbits, w_out32, w_en32, w_rd_val, w_out_nxt, w_en_nxt;
  logic            w_unused;

  for (genvar g = 0; g < IN_W; g++) begin : g_deb
    mmio_gpio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk     (clk),
      .reset_n (reset_n),
      .i_pin   (i_gpio_in[g]),
      .o_level (w_in[g]),
      .o_rise  (w_rise_p[g]),
      .o_fall  (w_fall_p[g])
    );
  end

  assign w_idx   = bus.mem_addr[4:2];
  assign w_req   = (r_state == ST_IDLE) && bus.mem_valid;
  assign w_wr    = w_req && (|bus.mem_wstrb);
  assign w_bmask = {{8{bus.mem_wstrb[3]}}, {8{bus.mem_wstrb[2]}},
                    {8{bus.mem_wstrb[1]}}, {8{bus.mem_wstrb[0]}}};
  assign w_wbits = bus.mem_wdata & w_bmask;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_out32 = '0;
    w_out32[OUT_W-1:0] = r_out;
    w_en32 = '0;
    w_en32[IN_W-1:0]   = r_en_rise;
    w_en32[16 +: IN_W] = r_en_fall;

    w_rd_val = '0;
    case (w_idx)
      REG_OUT, REG_SET, REG_CLR, REG_TOG: w_rd_val = w_out32;
      REG_IN:     w_rd_val[IN_W-1:0] = w_in;
      REG_RISE:   w_rd_val[IN_W-1:0] = r_rise;
      REG_FALL:   w_rd_val[IN_W-1:0] = r_fall;
      REG_IRQ_EN: w_rd_val = w_en32;
      default:    w_rd_val = '0;
    endcase

    w_out_nxt = w_out32;
    if (w_wr) begin
      case (w_idx)
        REG_OUT: w_out_nxt = (w_out32 & ~w_bmask) | w_wbits;
        REG_SET: w_out_nxt = w_out32 | w_wbits;
        REG_CLR: w_out_nxt = w_out32 & ~w_wbits;
        REG_TOG: w_out_nxt = w_out32 ^ w_wbits;
        default: w_out_nxt = w_out32;
      endcase
    end

    w_en_nxt   = (w_wr && w_idx == REG_IRQ_EN) ? ((w_en32 & ~w_bmask) | w_wbits) : w_en32;
    w_rise_clr = (w_wr && w_idx == REG_RISE) ? w_wbits[IN_W-1:0] : '0;
    w_fall_clr = (w_wr && w_idx == REG_FALL) ? w_wbits[IN_W-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_rdata   <= '0;
      r_out     <= OUT_RESET;
      r_rise    <= '0;
      r_fall    <= '0;
      r_en_rise <= '0;
      r_en_fall <= '0;
      r_irq     <= 1'b0;
    end else begin
      // RESP always returns to IDLE; mem_valid is only looked at in IDLE.
      r_state   <= w_req ? ST_RESP : ST_IDLE;
      if (w_req) r_rdata <= w_rd_val;
      r_out     <= w_out_nxt[OUT_W-1:0];
      // A hardware edge beats a simultaneous w1c of the same bit.
      r_rise    <= (r_rise & ~w_rise_clr) | w_rise_p;
      r_fall    <= (r_fall & ~w_fall_clr) | w_fall_p;
      r_en_rise <= w_en_nxt[IN_W-1:0];
      r_en_fall <= w_en_nxt[16 +: IN_W];
      r_irq     <= (|(r_rise & r_en_rise)) | (|(r_fall & r_en_fall));
    end
  end

  assign bus.mem_ready = (r_state == ST_RESP);
  assign bus.mem_rdata = r_rdata;
  assign o_gpio_out    = r_out;
  assign o_irq         = r_irq;

  assign w_unused = ^{bus.mem_addr[31:5], bus.mem_addr[1:0], w_out_nxt, w_en_nxt, w_wbits};

endmodule

// File: doc/mmio_gpio.md
# mmio_gpio

Parametrised memory-mapped GPIO peripheral for the Odeeen SoC on ULX3S. It generalises the single 8-bit LED register to OUT_W output pins and IN_W debounced input pins (buttons), with:
- byte-strobed writes and atomic set/clear/toggle of outputs;
- rising/falling edge capture on inputs, write-1-to-clear status;
- a maskable level interrupt.

It sits on the CPU's valid/ready memory bus behind the top-level address decoder, which gates mem_valid.

## Interface
- OUT_W, 8: output pin count, 1..32
- IN_W, 7: input pin count, 1..16
- OUT_RESET, 0: reset value of OUT, OUT_W bits
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles required before an input change is accepted (10 ms at 25 MHz); 0 = bypass, synchroniser only
- clk  in  1  system clock
- reset_n  in  1  reset, synchronous, active-low
- mem_valid  in  1  request, already gated by the decoder
- mem_ready  out  1  one-cycle acknowledge
- mem_addr  in  32  only [4:2] used as register index
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte strobes; 0 = read
- mem_rdata  out  32  read data, valid while mem_ready=1
- gpio_in  in  IN_W  asynchronous pins
- gpio_out  out  OUT_W  output pins, equal to OUT
- irq  out  1  registered interrupt level

## Operation
Register map (word index = mem_addr[4:2]):
- 0 OUT: rw.
- 1 SET: OUT |= wdata. Reads return OUT.
- 2 CLR: OUT &= ~wdata. Reads return OUT.
- 3 TOG: OUT ^= wdata. Reads return OUT.
- 4 IN: ro, debounced inputs.
- 5 RISE: w1c, rising-edge status.
- 6 FALL: w1c, falling-edge status.
- 7 IRQ_EN: rw. [IN_W-1:0] enables rise interrupts; [16+IN_W-1:16] enables fall interrupts.

Write rules:
- All writes honour mem_wstrb per byte. Bits outside a strobed byte are untouched, including for SET/CLR/TOG/w1c.
- Writes to IN are ignored.
- Unused upper bits read 0.

Input path, per bit:
- 2-flop synchroniser feeds the debouncer.
- The debouncer's counter restarts whenever the synchronised value equals the debounced value.
- When the synchronised value has differed from the debounced value for DEBOUNCE_CYCLES consecutive cycles, the debounced value takes the new value.
- A 0->1 change of the debounced value sets the RISE bit; a 1->0 change sets the FALL bit.

Interrupt: irq <= |(RISE & en_rise) | |(FALL & en_fall).

Boundary and simultaneous events:
- w1c of a status bit on the same edge a hardware edge sets it: set wins, bit stays 1.
- Input glitch shorter than DEBOUNCE_CYCLES: no change to IN, no status bit set.
- Read of RISE/FALL combined with w1c returns the pre-clear value.

Reset values: mem_ready=0, mem_rdata=0, gpio_out=OUT_RESET, irq=0. Synchronisers, debounced values, counters, RISE, FALL and IRQ_EN are all 0.

## Timing
Bus FSM, states IDLE and RESP:
- IDLE with mem_valid=1:
  - The write commits at that edge.
  - mem_rdata is registered from the pre-write register value.
  - FSM moves to RESP.
- RESP: mem_ready=1 for exactly one cycle, then IDLE unconditionally. mem_valid is not sampled in RESP.
- mem_valid still high in the cycle after RESP is treated as a new transaction.
- Result: fixed latency of 1 wait cycle; back-to-back accesses take 2 cycles each.
- mem_rdata holds its value outside RESP.

Other latencies:
- gpio_out changes the cycle after the write edge, coincident with mem_ready.
- gpio_in edge to IN: 2 sync cycles + DEBOUNCE_CYCLES + 1. With bypass: 3 cycles.
- Status bit set: same edge as the IN change. irq asserts 1 cycle later.
- irq deasserts 1 cycle after the clearing write commits.

Reset: reset_n low at any clock edge returns all state to reset values, including mid-transaction in RESP. An aborted transaction gets no mem_ready.

## Structure
- gpio_pkg: register index constants (REG_OUT..REG_IRQ_EN), bus state enum {IDLE, RESP}, and the debounce counter width function $clog2(DEBOUNCE_CYCLES+1).
- Sub-module gpio_debounce (one bit: synchroniser, counter, debounced output, rise/fall pulses), instantiated IN_W times via generate.
- Top-level integration: decoder enable replaces led_ctl_en; led = gpio_out[7:0].

## Test plan
- Reset with OUT_RESET=8'hA5: gpio_out=A5, irq=0, mem_ready=0; read OUT -> A5 with exactly 1 wait cycle.
- Write OUT=0x000000F0 with wstrb=0001 -> gpio_out=F0. Then SET 0x0F -> FF, CLR 0x81 -> 7E, TOG 0xFF -> 81; each gpio_out change coincides with mem_ready.
- Partial strobe, OUT_W=16, OUT=1234: write 0xABCD with wstrb=0010 -> OUT=AB34.
- DEBOUNCE_CYCLES=4: a 3-cycle pulse on gpio_in[0] -> IN=0, RISE=0. A held high -> IN bit0=1 and RISE bit0=1 after 2+4+1 cycles; irq=1 one cycle later only if IRQ_EN bit0=1.
- w1c RISE bit0 on the same edge as a new rising edge on bit0 -> RISE bit0 stays 1 and irq stays 1. A later w1c -> RISE=0, irq=0 one cycle after.
- Assert reset_n=0 during RESP -> mem_ready=0 next cycle and all registers at reset values; the next read of IRQ_EN -> 0.
